// File: rtl/exmem_pkg.sv
// Shared definitions for the EX/MEM pipeline register stage.
// Holds the skid-buffer state encoding and default payload widths.
package exmem_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_RD_W   = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } exmem_state_e;

endpackage

// File: rtl/exmem_stage_pipe_slot.sv
// One payload slot of the EX/MEM skid buffer: busC, busB, rd and wen
// registers that update only when load is asserted.
module pipe_slot #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] d_busC,
    input  logic [DATA_W-1:0] d_busB,
    input  logic [RD_W-1:0]   d_rd,
    input  logic              d_wen,
    output logic [DATA_W-1:0] q_busC,
    output logic [DATA_W-1:0] q_busB,
    output logic [RD_W-1:0]   q_rd,
    output logic              q_wen
);

    logic [DATA_W-1:0] busc_q, busc_d;
    logic [DATA_W-1:0] busb_q, busb_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              wen_q, wen_d;

    always_comb begin
        busc_d = busc_q;
        busb_d = busb_q;
        rd_d   = rd_q;
        wen_d  = wen_q;
        if (load) begin
            busc_d = d_busC;
            busb_d = d_busB;
            rd_d   = d_rd;
            wen_d  = d_wen;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busc_q <= '0;
            busb_q <= '0;
            rd_q   <= '0;
            wen_q  <= 1'b0;
        end else begin
            busc_q <= busc_d;
            busb_q <= busb_d;
            rd_q   <= rd_d;
            wen_q  <= wen_d;
        end
    end

    assign q_busC = busc_q;
    assign q_busB = busb_q;
    assign q_rd   = rd_q;
    assign q_wen  = wen_q;

endmodule

// File: rtl/exmem_stage.sv
// EX/MEM pipeline register built as a two-entry skid buffer so that
// in_ready can be registered without losing the entry accepted while MEM stalls.
module exmem_stage
    import exmem_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int RD_W   = DEFAULT_RD_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_busC,
    input  logic [DATA_W-1:0] in_busB,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_wen,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_busC,
    output logic [DATA_W-1:0] out_busB,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_wen,
    output logic [CNT_W-1:0]  stall_cnt
);

    exmem_state_e      state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic              xfer_in, xfer_out;
    logic              main_load, skid_load, main_from_skid;
    logic              cap_wen;

    logic [DATA_W-1:0] skid_busC, skid_busB;
    logic [RD_W-1:0]   skid_rd;
    logic              skid_wen;

    logic [DATA_W-1:0] main_in_busC, main_in_busB;
    logic [RD_W-1:0]   main_in_rd;
    logic              main_in_wen;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign xfer_in   = in_valid && in_ready_q;
    assign xfer_out  = out_valid && out_ready;
    // Register 0 is hard-wired; never let a write to it travel downstream.
    assign cap_wen   = in_wen && (in_rd != '0);

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (xfer_in) begin
                    state_d   = FULL;
                    main_load = 1'b1;
                end
            end
            FULL: begin
                if (xfer_in && xfer_out) begin
                    main_load = 1'b1;
                end else if (xfer_out) begin
                    state_d = EMPTY;
                end else if (xfer_in) begin
                    state_d   = SKID;
                    skid_load = 1'b1;
                end
            end
            SKID: begin
                if (xfer_out) begin
                    state_d        = FULL;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Kill wins over any transfer in the same cycle, including captures.
        if (flush) begin
            state_d   = EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    always_comb begin
        in_ready_d = (state_d != SKID);
        stall_d    = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_comb begin
        main_in_busC = in_busC;
        main_in_busB = in_busB;
        main_in_rd   = in_rd;
        main_in_wen  = cap_wen;
        if (main_from_skid) begin
            main_in_busC = skid_busC;
            main_in_busB = skid_busB;
            main_in_rd   = skid_rd;
            main_in_wen  = skid_wen;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            stall_q    <= stall_d;
        end
    end

    assign stall_cnt = stall_q;

    pipe_slot #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (main_load),
        .d_busC (main_in_busC),
        .d_busB (main_in_busB),
        .d_rd   (main_in_rd),
        .d_wen  (main_in_wen),
        .q_busC (out_busC),
        .q_busB (out_busB),
        .q_rd   (out_rd),
        .q_wen  (out_wen)
    );

    pipe_slot #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (skid_load),
        .d_busC (in_busC),
        .d_busB (in_busB),
        .d_rd   (in_rd),
        .d_wen  (cap_wen),
        .q_busC (skid_busC),
        .q_busB (skid_busB),
        .q_rd   (skid_rd),
        .q_wen  (skid_wen)
    );

endmodule

// File: tb/tb_exmem_stage.sv
// Directed self-checking bench for exmem_stage: streaming, backpressure,
// flush, rd=0 write suppression, asynchronous reset and counter saturation.
module tb_exmem_stage;

    localparam int DATA_W = 32;
    localparam int RD_W   = 5;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_busC;
    logic [DATA_W-1:0] in_busB;
    logic [RD_W-1:0]   in_rd;
    logic              in_wen;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_busC;
    logic [DATA_W-1:0] out_busB;
    logic [RD_W-1:0]   out_rd;
    logic              out_wen;
    logic [CNT_W-1:0]  stall_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    exmem_stage #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_busC   (in_busC),
        .in_busB   (in_busB),
        .in_rd     (in_rd),
        .in_wen    (in_wen),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_busC  (out_busC),
        .out_busB  (out_busB),
        .out_rd    (out_rd),
        .out_wen   (out_wen),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are then driven and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_busC   = '0;
        in_busB   = '0;
        in_rd     = '0;
        in_wen    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready);
        else pass_cnt++;
        total_cnt++;
        if ({out_busC, out_busB, out_rd, out_wen} !== '0)
            $display("FAIL reset_payload got busC=%h busB=%h rd=%0d wen=%0b want all 0",
                     out_busC, out_busB, out_rd, out_wen);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== 4'd0) $display("FAIL reset_stall got %0d want 0", stall_cnt);
        else pass_cnt++;
        rst_n = 1'b1;
        $display("reset: checked idle outputs");
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_rd     = 5'd1;
        in_wen    = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_busC = DATA_W'(i);
            in_busB = DATA_W'(i * 16);
            tick();
            $display("stream: sent busC=%0d, out busC=%0d valid=%0b ready=%0b",
                     i, out_busC, out_valid, in_ready);
            total_cnt++;
            if (out_valid !== 1'b1 || out_busC !== DATA_W'(i) || out_busB !== DATA_W'(i * 16))
                $display("FAIL stream_data%0d got valid=%0b busC=%0d busB=%0d want valid=1 busC=%0d busB=%0d",
                         i, out_valid, out_busC, out_busB, i, i * 16);
            else pass_cnt++;
            total_cnt++;
            if (in_ready !== 1'b1) $display("FAIL stream_ready%0d got %0b want 1", i, in_ready);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL stream_drain got valid=%0b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== 4'd0) $display("FAIL stream_stall got %0d want 0", stall_cnt);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_busC   = 32'h10;
        in_busB   = 32'hA1;
        in_rd     = 5'd3;
        in_wen    = 1'b1;
        tick();
        $display("backpressure: sent A busC=0x10, out busC=%h", out_busC);
        in_busC = 32'h20;
        in_busB = 32'hB2;
        in_rd   = 5'd4;
        tick();
        $display("backpressure: sent B busC=0x20, in_ready=%0b", in_ready);
        in_valid = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL bp_skid_ready got %0b want 0", in_ready);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_busC !== 32'h10 || out_busB !== 32'hA1 || out_rd !== 5'd3)
            $display("FAIL bp_hold_A got valid=%0b busC=%h busB=%h rd=%0d want 1 10 a1 3",
                     out_valid, out_busC, out_busB, out_rd);
        else pass_cnt++;
        out_ready = 1'b1;
        tick();
        $display("backpressure: released, out busC=%h", out_busC);
        total_cnt++;
        if (out_valid !== 1'b1 || out_busC !== 32'h20 || out_busB !== 32'hB2 || out_rd !== 5'd4)
            $display("FAIL bp_then_B got valid=%0b busC=%h busB=%h rd=%0d want 1 20 b2 4",
                     out_valid, out_busC, out_busB, out_rd);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %0b want 1", in_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL bp_drain got valid=%0b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== 4'd3) $display("FAIL bp_stall_cnt got %0d want 3", stall_cnt);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_busC   = 32'h11;
        tick();
        in_busC = 32'h22;
        tick();
        flush   = 1'b1;
        in_busC = 32'h33;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        $display("flush: flushed in SKID with in_valid=1, out_valid=%0b", out_valid);
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_state got valid=%0b ready=%0b want 0 1", out_valid, in_ready);
        else pass_cnt++;
        out_ready = 1'b1;
        tick();
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL flush_no_emerge got valid=%0b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== 4'd2) $display("FAIL flush_stall_kept got %0d want 2", stall_cnt);
        else pass_cnt++;
    endtask

    task automatic test_wen_rd0();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_busC   = 32'h5;
        in_rd     = 5'd0;
        in_wen    = 1'b1;
        tick();
        $display("wen: rd=0 wen=1 -> out_wen=%0b", out_wen);
        total_cnt++;
        if (out_valid !== 1'b1 || out_wen !== 1'b0)
            $display("FAIL wen_rd0 got valid=%0b wen=%0b want 1 0", out_valid, out_wen);
        else pass_cnt++;
        in_rd = 5'd7;
        tick();
        $display("wen: rd=7 wen=1 -> out_wen=%0b", out_wen);
        total_cnt++;
        if (out_wen !== 1'b1 || out_rd !== 5'd7)
            $display("FAIL wen_rd7 got wen=%0b rd=%0d want 1 7", out_wen, out_rd);
        else pass_cnt++;
        in_wen = 1'b0;
        tick();
        total_cnt++;
        if (out_wen !== 1'b0) $display("FAIL wen_off got %0b want 0", out_wen);
        else pass_cnt++;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_busC   = 32'h40;
        in_busB   = 32'h41;
        in_rd     = 5'd9;
        in_wen    = 1'b1;
        tick();
        in_busC = 32'h50;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        $display("async_reset: asserted mid-SKID, out_valid=%0b", out_valid);
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 4'd0)
            $display("FAIL areset_ctrl got valid=%0b ready=%0b stall=%0d want 0 1 0",
                     out_valid, in_ready, stall_cnt);
        else pass_cnt++;
        total_cnt++;
        if ({out_busC, out_busB, out_rd, out_wen} !== '0)
            $display("FAIL areset_payload got busC=%h busB=%h rd=%0d wen=%0b want all 0",
                     out_busC, out_busB, out_rd, out_wen);
        else pass_cnt++;
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_busC  = 32'h55;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_busC !== 32'h55 || in_ready !== 1'b1)
            $display("FAIL areset_recapture got valid=%0b busC=%h ready=%0b want 1 55 1",
                     out_valid, out_busC, in_ready);
        else pass_cnt++;
        for (int i = 0; i < 20; i++) tick();
        $display("saturate: 20 stall cycles, stall_cnt=%0d", stall_cnt);
        total_cnt++;
        if (stall_cnt !== 4'd15) $display("FAIL stall_saturate got %0d want 15", stall_cnt);
        else pass_cnt++;
        total_cnt++;
        if (out_busC !== 32'h55) $display("FAIL saturate_hold got busC=%h want 55", out_busC);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_wen_rd0();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/exmem_stage.md
EXMEM_STAGE -- requirements
Module: exmem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of busC/busB payloads.
REQ-002 SHALL have parameter RD_W, default 5, width of destination register index.
REQ-003 SHALL have parameter CNT_W, default 16, width of stall counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  discard all held entries (branch/exception kill).
REQ-007 in_valid  input  1  upstream (EX) entry present.
REQ-008 in_ready  output  1  stage can accept this cycle; registered, depends only on state.
REQ-009 in_busC  input  DATA_W  ALU result.
REQ-010 in_busB  input  DATA_W  store data.
REQ-011 in_rd  input  RD_W  destination register.
REQ-012 in_wen  input  1  register write enable.
REQ-013 out_valid  output  1  entry presented to MEM.
REQ-014 out_ready  input  1  MEM accepts this cycle.
REQ-015 out_busC, out_busB  output  DATA_W  held payloads.
REQ-016 out_rd  output  RD_W; out_wen  output  1.
REQ-017 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-018 Stage SHALL be a two-entry skid buffer: main slot drives outputs, skid slot catches the entry accepted while main is blocked.
REQ-019 States SHALL be EMPTY (no entry), FULL (main only), SKID (main and skid).
REQ-020 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-021 EMPTY: in -> FULL, captured into main; latency one cycle from in to out_valid.
REQ-022 FULL: in and out -> FULL with new main; out only -> EMPTY; in only -> SKID with entry in skid; neither -> FULL.
REQ-023 SKID: out -> FULL, skid moves to main; else hold; in_ready SHALL be 0 in SKID, 1 in EMPTY/FULL.
REQ-024 out_valid SHALL be 1 in FULL and SKID; payload outputs SHALL be stable while out_valid && !out_ready.
REQ-025 Entries SHALL leave in arrival order; no entry dropped or duplicated absent flush.
REQ-026 On capture, stored wen SHALL be in_wen && (in_rd != 0); writes to register 0 are suppressed.
REQ-027 flush SHALL force next state EMPTY, overriding any simultaneous in/out transfer; entries present on in that cycle are discarded.
REQ-028 Payload registers SHALL load only on capture; no change while held.
REQ-029 stall_cnt SHALL increment by one per stall cycle, saturate at all-ones, not clear on flush.

Reset
REQ-030 rst_n low SHALL immediately force state EMPTY, out_valid=0, in_ready=1, out_wen=0, out_busC=0, out_busB=0, out_rd=0, stall_cnt=0.
REQ-031 Reset mid-operation SHALL discard both slots; first post-reset capture behaves as from EMPTY.

Structure
REQ-032 Shared package exmem_pkg SHALL hold state enum (EMPTY/FULL/SKID) and default DATA_W/RD_W constants.
REQ-033 One sub-module pipe_slot (DATA_W payload + rd + wen register with load enable) SHALL be instantiated twice (main, skid).

Verification
REQ-034 Stream: in_valid=1 with busC=1,2,3, out_ready=1 -> out busC 1,2,3 on consecutive cycles, one-cycle latency, in_ready stays 1.
REQ-035 Backpressure: out_ready=0 after entry A=0x10, send B=0x20 -> state SKID, in_ready=0; release -> A then B, stall_cnt equals blocked cycles.
REQ-036 Flush in SKID with simultaneous in_valid -> next cycle out_valid=0, in_ready=1, no entry emerges.
REQ-037 Capture rd=0, wen=1 -> out_wen=0; rd=7, wen=1 -> out_wen=1.
REQ-038 Assert rst_n low mid-SKID, asynchronous to clk -> outputs zero immediately; stall_cnt with CNT_W=4 held 20 cycles saturates at 15.
